// File: rtl/p2s_conv_8x1.sv
// ---------------------------------------------------------------------------
// p2s_conv_8x1 -- parallel-to-serial converter
//
// Takes DATA_W-bit words on a valid/ready handshake and emits them one bit per
// transfer, MSB first by default. A one-word holding register lets the next
// word queue up while the current one shifts out, so back-to-back words leave
// without a bubble. This is the transmit-side partner of the 1x8
// serial-to-parallel converter.
//
// Build option:
//   P2S_LSB_FIRST_EN  when defined, words leave LSB first (odat = SR[0] and
//                     SR shifts right). Handshake, olast and timing do not
//                     change.
//
// Ports:
//   iclk       in   1       clock, all logic on posedge
//   irst       in   1       asynchronous active-low reset
//   idat       in   DATA_W  parallel word in
//   ival       in   1       idat valid
//   oreq       out  1       ready for a word (accept = ival & oreq)
//   ireq       in   1       downstream ready (transfer = oval & ireq)
//   oval       out  1       serial bit valid
//   odat       out  1       serial bit
//   olast      out  1       current bit is the last bit of its word
//   ounderrun  out  1       registered flag: downstream asked for a bit while
//                           none was available, after at least one word went out
// ---------------------------------------------------------------------------
module p2s_conv_8x1 #(
    parameter int DATA_W = 8
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic [DATA_W-1:0] idat,
    input  logic              ival,
    output logic              oreq,
    input  logic              ireq,
    output logic              oval,
    output logic              odat,
    output logic              olast,
    output logic              ounderrun
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] sr_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] hr_r;
    logic              hr_full_r;
    logic              rdy_r;       // holds oreq low while in reset and for the first edge after
    logic              sent_r;      // at least one complete word left since reset
    logic              underrun_r;

    logic              accept_s;
    logic              xfer_s;
    logic              last_xfer_s;
    logic              sr_free_s;
    logic [DATA_W-1:0] shifted_s;

    // Output decode straight from registers; oreq has no path from ival or ireq.
    assign oval      = (state_r == ST_SHIFT);
    assign olast     = oval & (bit_cnt_r == CNT_ZERO);
    assign oreq      = rdy_r & ~hr_full_r;
    assign ounderrun = underrun_r;
`ifdef P2S_LSB_FIRST_EN
    assign odat      = sr_r[0];
`else
    assign odat      = sr_r[DATA_W-1];
`endif

    // Handshake qualifiers and the next shift-register value.
    always_comb begin
        accept_s    = ival & oreq;
        xfer_s      = oval & ireq;
        last_xfer_s = olast & ireq;
        // SR can take a new word next edge if it is empty or its last bit leaves
        // now with nothing queued in HR.
        sr_free_s   = (state_r == ST_IDLE) | (last_xfer_s & ~hr_full_r);
`ifdef P2S_LSB_FIRST_EN
        shifted_s   = {1'b0, sr_r[DATA_W-1:1]};
`else
        shifted_s   = {sr_r[DATA_W-2:0], 1'b0};
`endif
    end

    // Shift register, bit counter and IDLE/SHIFT state.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state_r   <= ST_IDLE;
            sr_r      <= {DATA_W{1'b0}};
            bit_cnt_r <= CNT_ZERO;
        end else begin
            if (accept_s && sr_free_s) begin
                sr_r      <= idat;
                bit_cnt_r <= CNT_TOP;
                state_r   <= ST_SHIFT;
            end else if (last_xfer_s && hr_full_r) begin
                // Queued word follows immediately, no bubble.
                sr_r      <= hr_r;
                bit_cnt_r <= CNT_TOP;
                state_r   <= ST_SHIFT;
            end else if (last_xfer_s) begin
                sr_r      <= {DATA_W{1'b0}};
                bit_cnt_r <= CNT_ZERO;
                state_r   <= ST_IDLE;
            end else if (xfer_s) begin
                sr_r      <= shifted_s;
                bit_cnt_r <= bit_cnt_r - CNT_ONE;
                state_r   <= state_r;
            end else begin
                sr_r      <= sr_r;
                bit_cnt_r <= bit_cnt_r;
                state_r   <= state_r;
            end
        end
    end

    // Holding register: catches a word accepted while SR is still busy.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            hr_r      <= {DATA_W{1'b0}};
            hr_full_r <= 1'b0;
        end else begin
            if (accept_s && !sr_free_s) begin
                hr_r      <= idat;
                hr_full_r <= 1'b1;
            end else if (last_xfer_s && hr_full_r) begin
                hr_r      <= hr_r;
                hr_full_r <= 1'b0;
            end else begin
                hr_r      <= hr_r;
                hr_full_r <= hr_full_r;
            end
        end
    end

    // Ready enable, sent flag and the underrun diagnostic.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            rdy_r      <= 1'b0;
            sent_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            rdy_r      <= 1'b1;
            sent_r     <= sent_r | last_xfer_s;
            underrun_r <= ireq & ~oval & sent_r;
        end
    end

endmodule
